// File: rtl/oddr_ddr.sv
// oddr_ddr: generic double-data-rate output register built from flops on
// both clock edges plus an output select; no vendor primitive needed.
//
// Parameters:
//   DDR_CLK_EDGE "SAME_EDGE" | "OPPOSITE_EDGE"  capture mode
//   INIT         power-up value of Q and every internal register
// Ports:
//   C   in   clock, both edges used
//   R   in   asynchronous reset, active-high, forces Q=0 (wins over S)
//   S   in   asynchronous set, active-high, forces Q=1
//   CE  in   clock enable, active-high
//   D1  in   data for the high half of the output cycle
//   D2  in   data for the low half of the output cycle
//   Q   out  double-data-rate output
module oddr_ddr #(
    parameter string DDR_CLK_EDGE = "SAME_EDGE",
    parameter logic  INIT         = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic S,
    input  logic CE,
    input  logic D1,
    input  logic D2,
    output logic Q
);

    localparam bit SAME  = (DDR_CLK_EDGE == "SAME_EDGE");
    localparam bit OPP   = (DDR_CLK_EDGE == "OPPOSITE_EDGE");
    localparam bit LEGAL = SAME || OPP;

    generate
        if (!LEGAL) begin : g_bad_mode
            $error("oddr_ddr: illegal DDR_CLK_EDGE '%s'", DDR_CLK_EDGE);
        end
    endgenerate

    // Set is gated by reset so that releasing R while S is still high
    // produces a fresh preset event and the registers move to 1.
    logic set_eff;
    assign set_eff = S & ~R;

    // Rising-edge domain: D1 data, stored D2 (same-edge mode) and a
    // toggle that flips on every rising-edge load.
    logic r1_q   = INIT;
    logic r2_q   = INIT;
    logic rtog_q = INIT;
    logic r1_d;
    logic r2_d;
    logic rtog_d;

    // Falling-edge domain: low-half data and a toggle copied from the
    // rising side whenever the falling edge loads.
    logic f_q    = INIT;
    logic ftog_q = INIT;
    logic f_d;
    logic ftog_d;

    // Toggles differ exactly when the rising edge loaded last, so the
    // output shows the rising-edge data; otherwise the falling data.
    logic rise_last;
    assign rise_last = (rtog_q != ftog_q);

    always_comb begin
        r1_d   = r1_q;
        r2_d   = r2_q;
        rtog_d = rtog_q;
        if (LEGAL && CE) begin
            r1_d   = D1;
            r2_d   = SAME ? D2 : r2_q;
            rtog_d = ~rtog_q;
        end
    end

    always_comb begin
        f_d    = f_q;
        ftog_d = ftog_q;
        if (SAME) begin
            // A pending rising-edge load means CE was 1 at that edge;
            // hand its stored D2 to the low half.
            if (rise_last) begin
                f_d    = r2_q;
                ftog_d = rtog_q;
            end
        end else if (OPP && CE) begin
            f_d    = D2;
            ftog_d = rtog_q;
        end
    end

    always_ff @(posedge C or posedge R or posedge set_eff) begin
        if (R) begin
            r1_q   <= 1'b0;
            r2_q   <= 1'b0;
            rtog_q <= 1'b0;
        end else if (set_eff) begin
            r1_q   <= 1'b1;
            r2_q   <= 1'b1;
            rtog_q <= 1'b1;
        end else begin
            r1_q   <= r1_d;
            r2_q   <= r2_d;
            rtog_q <= rtog_d;
        end
    end

    always_ff @(negedge C or posedge R or posedge set_eff) begin
        if (R) begin
            f_q    <= 1'b0;
            ftog_q <= 1'b0;
        end else if (set_eff) begin
            f_q    <= 1'b1;
            ftog_q <= 1'b1;
        end else begin
            f_q    <= f_d;
            ftog_q <= ftog_d;
        end
    end

    assign Q = rise_last ? r1_q : f_q;

endmodule

// File: tb/tb_oddr_ddr.sv
// tb_oddr_ddr: scoreboard bench for oddr_ddr in both capture modes and
// with INIT=1 power-up.
module tb_oddr_ddr;

    logic C  = 1'b0;
    logic Ci = 1'b0;
    logic R  = 1'b0;
    logic Ri = 1'b0;
    logic S  = 1'b0;
    logic Si = 1'b0;
    logic CE = 1'b1;
    logic D1 = 1'b0;
    logic D2 = 1'b0;
    logic q_se;
    logic q_oe;
    logic q_in;

    int total = 0;
    int bad   = 0;
    logic sb[$];

    oddr_ddr #(.DDR_CLK_EDGE("SAME_EDGE"), .INIT(1'b0)) dut_se (
        .C(C), .R(R), .S(S), .CE(CE), .D1(D1), .D2(D2), .Q(q_se)
    );

    oddr_ddr #(.DDR_CLK_EDGE("OPPOSITE_EDGE"), .INIT(1'b0)) dut_oe (
        .C(C), .R(R), .S(S), .CE(CE), .D1(D1), .D2(D2), .Q(q_oe)
    );

    oddr_ddr #(.DDR_CLK_EDGE("SAME_EDGE"), .INIT(1'b1)) dut_in (
        .C(Ci), .R(Ri), .S(Si), .CE(CE), .D1(D1), .D2(D2), .Q(q_in)
    );

    always #5 C = ~C;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic test_reset;
        #1;
        total++;
        if (q_se !== 1'b0) begin
            bad++;
            $display("FAIL pwr_se got=%b want=0", q_se);
        end
        total++;
        if (q_in !== 1'b1) begin
            bad++;
            $display("FAIL pwr_init got=%b want=1", q_in);
        end
        R  = 1'b1;
        Ri = 1'b1;
        #1;
        total++;
        if (q_oe !== 1'b0) begin
            bad++;
            $display("FAIL rst_oe got=%b want=0", q_oe);
        end
        total++;
        if (q_in !== 1'b0) begin
            bad++;
            $display("FAIL rst_init got=%b want=0", q_in);
        end
        R  = 1'b0;
        Ri = 1'b0;
        #1;
        total++;
        if (q_in !== 1'b0) begin
            bad++;
            $display("FAIL rst_init_rel got=%b want=0", q_in);
        end
        @(negedge C);
        #2;
    endtask

    task automatic test_square;
        logic e;
        for (int i = 0; i < 4; i++) begin
            D1 = 1'b1;
            D2 = 1'b0;
            CE = 1'b1;
            sb.push_back(1'b1);
            sb.push_back(1'b0);
            @(posedge C);
            #2;
            e = sb.pop_front();
            total++;
            if (q_se !== e) begin
                bad++;
                $display("FAIL square_hi[%0d] got=%b want=%b", i, q_se, e);
            end
            @(negedge C);
            #2;
            e = sb.pop_front();
            total++;
            if (q_se !== e) begin
                bad++;
                $display("FAIL square_lo[%0d] got=%b want=%b", i, q_se, e);
            end
        end
    endtask

    task automatic test_pairs;
        logic [2:0] d1v = 3'b101;
        logic [2:0] d2v = 3'b011;
        logic e;
        for (int i = 0; i < 3; i++) begin
            D1 = d1v[2-i];
            D2 = d2v[2-i];
            CE = 1'b1;
            sb.push_back(d1v[2-i]);
            sb.push_back(d2v[2-i]);
            @(posedge C);
            #2;
            e = sb.pop_front();
            total++;
            if (q_se !== e) begin
                bad++;
                $display("FAIL pairs_hi[%0d] got=%b want=%b", i, q_se, e);
            end
            @(negedge C);
            #2;
            e = sb.pop_front();
            total++;
            if (q_se !== e) begin
                bad++;
                $display("FAIL pairs_lo[%0d] got=%b want=%b", i, q_se, e);
            end
        end
    endtask

    task automatic test_ce_stall;
        logic [4:0] d1v = 5'b10000;
        logic [4:0] d2v = 5'b10001;
        logic [4:0] cev = 5'b10001;
        logic last = 1'b0;
        logic e;
        for (int i = 0; i < 5; i++) begin
            D1 = d1v[4-i];
            D2 = d2v[4-i];
            CE = cev[4-i];
            if (cev[4-i]) begin
                sb.push_back(d1v[4-i]);
                sb.push_back(d2v[4-i]);
                last = d2v[4-i];
            end else begin
                sb.push_back(last);
                sb.push_back(last);
            end
            @(posedge C);
            #2;
            e = sb.pop_front();
            total++;
            if (q_se !== e) begin
                bad++;
                $display("FAIL stall_hi[%0d] got=%b want=%b", i, q_se, e);
            end
            @(negedge C);
            #2;
            e = sb.pop_front();
            total++;
            if (q_se !== e) begin
                bad++;
                $display("FAIL stall_lo[%0d] got=%b want=%b", i, q_se, e);
            end
        end
        CE = 1'b1;
    endtask

    task automatic test_toggle;
        logic e;
        D1 = 1'b1;
        D2 = 1'b0;
        sb.push_back(1'b1);
        sb.push_back(1'b0);
        @(posedge C);
        #1;
        D1 = 1'b0;
        D2 = 1'b1;
        #1;
        e = sb.pop_front();
        total++;
        if (q_se !== e) begin
            bad++;
            $display("FAIL toggle_hi got=%b want=%b", q_se, e);
        end
        @(negedge C);
        #2;
        e = sb.pop_front();
        total++;
        if (q_se !== e) begin
            bad++;
            $display("FAIL toggle_lo got=%b want=%b", q_se, e);
        end
    endtask

    task automatic test_async;
        logic e;
        D1 = 1'b1;
        D2 = 1'b1;
        CE = 1'b1;
        @(posedge C);
        #2;
        total++;
        if (q_se !== 1'b1) begin
            bad++;
            $display("FAIL async_pre got=%b want=1", q_se);
        end
        R = 1'b1;
        #1;
        total++;
        if (q_se !== 1'b0) begin
            bad++;
            $display("FAIL async_r got=%b want=0", q_se);
        end
        @(negedge C);
        #1;
        total++;
        if (q_se !== 1'b0) begin
            bad++;
            $display("FAIL r_hold_lo got=%b want=0", q_se);
        end
        @(posedge C);
        #1;
        total++;
        if (q_se !== 1'b0) begin
            bad++;
            $display("FAIL r_hold_hi got=%b want=0", q_se);
        end
        S = 1'b1;
        #1;
        total++;
        if (q_se !== 1'b0) begin
            bad++;
            $display("FAIL rs_prio got=%b want=0", q_se);
        end
        R = 1'b0;
        #1;
        total++;
        if (q_se !== 1'b1) begin
            bad++;
            $display("FAIL set_only got=%b want=1", q_se);
        end
        total++;
        if (q_oe !== 1'b1) begin
            bad++;
            $display("FAIL set_only_oe got=%b want=1", q_oe);
        end
        @(negedge C);
        #1;
        S = 1'b0;
        #1;
        total++;
        if (q_se !== 1'b1) begin
            bad++;
            $display("FAIL set_rel got=%b want=1", q_se);
        end
        // one disabled cycle: forced value must persist across both edges
        CE = 1'b0;
        D1 = 1'b0;
        D2 = 1'b0;
        sb.push_back(1'b1);
        sb.push_back(1'b1);
        @(posedge C);
        #2;
        e = sb.pop_front();
        total++;
        if (q_se !== e) begin
            bad++;
            $display("FAIL hold_hi got=%b want=%b", q_se, e);
        end
        @(negedge C);
        #2;
        e = sb.pop_front();
        total++;
        if (q_se !== e) begin
            bad++;
            $display("FAIL hold_lo got=%b want=%b", q_se, e);
        end
        CE = 1'b1;
        D2 = 1'b1;
        sb.push_back(1'b0);
        sb.push_back(1'b1);
        @(posedge C);
        #2;
        e = sb.pop_front();
        total++;
        if (q_se !== e) begin
            bad++;
            $display("FAIL resume_hi got=%b want=%b", q_se, e);
        end
        @(negedge C);
        #2;
        e = sb.pop_front();
        total++;
        if (q_se !== e) begin
            bad++;
            $display("FAIL resume_lo got=%b want=%b", q_se, e);
        end
    endtask

    task automatic test_override;
        logic e;
        D1 = 1'b1;
        D2 = 1'b0;
        CE = 1'b1;
        @(posedge C);
        #2;
        total++;
        if (q_se !== 1'b1) begin
            bad++;
            $display("FAIL ovr_hi got=%b want=1", q_se);
        end
        S = 1'b1;
        #1;
        S = 1'b0;
        @(negedge C);
        #2;
        total++;
        if (q_se !== 1'b1) begin
            bad++;
            $display("FAIL ovr_lo got=%b want=1", q_se);
        end
        D1 = 1'b0;
        D2 = 1'b1;
        sb.push_back(1'b0);
        sb.push_back(1'b1);
        @(posedge C);
        #2;
        e = sb.pop_front();
        total++;
        if (q_se !== e) begin
            bad++;
            $display("FAIL restart_hi got=%b want=%b", q_se, e);
        end
        @(negedge C);
        #2;
        e = sb.pop_front();
        total++;
        if (q_se !== e) begin
            bad++;
            $display("FAIL restart_lo got=%b want=%b", q_se, e);
        end
    endtask

    task automatic test_opposite;
        logic [3:0] d1v = 4'b1101;
        logic [3:0] d2v = 4'b0110;
        logic e;
        for (int i = 0; i < 4; i++) begin
            // D2 holds a decoy at the rising edge; only its value at the
            // falling edge may reach Q.
            D1 = d1v[3-i];
            D2 = ~d2v[3-i];
            CE = 1'b1;
            sb.push_back(d1v[3-i]);
            sb.push_back(d2v[3-i]);
            @(posedge C);
            #2;
            e = sb.pop_front();
            total++;
            if (q_oe !== e) begin
                bad++;
                $display("FAIL opp_hi[%0d] got=%b want=%b", i, q_oe, e);
            end
            #1;
            D2 = d2v[3-i];
            @(negedge C);
            #2;
            e = sb.pop_front();
            total++;
            if (q_oe !== e) begin
                bad++;
                $display("FAIL opp_lo[%0d] got=%b want=%b", i, q_oe, e);
            end
        end
        D1 = 1'b0;
        D2 = 1'b1;
        sb.push_back(1'b0);
        sb.push_back(1'b0);
        @(posedge C);
        #2;
        e = sb.pop_front();
        total++;
        if (q_oe !== e) begin
            bad++;
            $display("FAIL opp_ce_hi got=%b want=%b", q_oe, e);
        end
        #1;
        CE = 1'b0;
        @(negedge C);
        #2;
        e = sb.pop_front();
        total++;
        if (q_oe !== e) begin
            bad++;
            $display("FAIL opp_ce_lo got=%b want=%b", q_oe, e);
        end
        CE = 1'b1;
    endtask

    initial begin
        test_reset();
        test_square();
        test_pairs();
        test_ce_stall();
        test_toggle();
        test_async();
        test_override();
        test_opposite();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oddr_ddr.md
ODDR_DDR -- requirements
Module: oddr

Interface
REQ-001 Parameter DDR_CLK_EDGE, default "SAME_EDGE", capture mode; legal values "SAME_EDGE" and "OPPOSITE_EDGE".
REQ-002 Parameter INIT, default 1'b0, power-up value of Q and of all internal registers before the first reset or clock.
REQ-003 C  input  1  clock; one clock domain only, both edges used.
REQ-004 R  input  1  reset; asynchronous, active-high.
REQ-005 S  input  1  set; asynchronous, active-high.
REQ-006 CE  input  1  clock enable, active-high.
REQ-007 D1  input  1  data for the rising-edge half of the output cycle.
REQ-008 D2  input  1  data for the falling-edge half of the output cycle.
REQ-009 Q  output  1  double-data-rate output.

Function
REQ-010 Q is driven from a register, never combinationally from D1/D2.
REQ-011 SAME_EDGE mode:
- On each rising edge of C with CE=1, the block samples D1 and D2 together.
- Q takes the sampled D1 at that rising edge.
- Q takes the sampled D2 at the following falling edge.
REQ-012 SAME_EDGE latency: D1 appears at Q 0 half-cycles after its sampling edge, and D2 appears 1 half-cycle after it.
REQ-013 OPPOSITE_EDGE mode:
- D1 is sampled on the rising edge of C and drives Q from that rising edge.
- D2 is sampled on the falling edge of C and drives Q from that falling edge.
REQ-014 CE=0 holds all internal registers at either edge, so Q keeps its current value. Once CE returns to 1, the next rising edge resumes normal operation.
REQ-015 CE sampling:
- In SAME_EDGE mode, CE is sampled at the rising edge only. The falling-edge transfer of the stored D2 occurs if CE was 1 at the preceding rising edge.
- In OPPOSITE_EDGE mode, CE is sampled at each edge independently.
REQ-016 R=1 forces Q and all internal registers to 0 immediately, with no clock edge required.
REQ-017 S=1 with R=0 forces Q and all internal registers to 1 immediately.
REQ-018 R has priority over S when both are 1.
REQ-019 While R or S is asserted, clock edges and CE have no effect.
REQ-020 When R or S deasserts, Q holds the forced value until the next enabled clock edge loads new data.
REQ-021 Reset or set asserted mid-cycle overrides any pending falling-edge D2 transfer. After release, output restarts from the next rising edge.
REQ-022 An illegal DDR_CLK_EDGE value shall be flagged at elaboration, and the block shall not operate in that configuration.
REQ-023 Toggling D1/D2 between edges shall not change Q; only sampled values propagate.
REQ-024 The block shall be synthesizable from generic flip-flops on both clock edges plus an output select, with no vendor primitive required.

Reset
REQ-025 Power-up value of Q is INIT.
REQ-026 Any assertion of R gives Q=0 within the same simulation delta, regardless of the C phase.
REQ-027 The first valid data after R is released is the D1 sampled at the first rising edge with CE=1.

Verification
REQ-028 SAME_EDGE, CE=1, R=S=0, drive D1=1/D2=0 every cycle -> Q toggles 1 in the high phase and 0 in the low phase, producing a square wave at C frequency and in phase with C.
REQ-029 SAME_EDGE, drive D1/D2 pairs (1,1), (0,1), (1,0) on successive rising edges -> Q sequence per half-cycle is 1,1,0,1,1,0.
REQ-030 CE stall:
- Stimulus: after Q=1 from D1=1, set CE=0 and change D1=0, D2=0 for 3 cycles.
- Required response: Q stays 1 throughout; after CE=1, the next rising edge gives Q=D1.
REQ-031 Asynchronous reset and priority:
- Stimulus: assert R in the middle of the C high phase while Q=1.
- Required response: Q=0 immediately, and stays 0 through edges while R=1.
- Stimulus: assert S and R together.
- Required response: Q=0.
- Stimulus: release R with S still 1.
- Required response: Q=1.
REQ-032 OPPOSITE_EDGE, D1=1 stable, change D2 from 0 to 1 just before a falling edge -> Q becomes 1 at that falling edge. The D2 value just before the rising edge is irrelevant.
REQ-033 Power-up check: with INIT=1 and no clock or reset activity, Q=1; after the first R pulse, Q=0.
